// File: rtl/fakeram130_1r1w_init.sv
// fakeram130_1r1w_init: behavioural 1-read / 1-write RAM with per-bit write
// mask, selectable read latency (1 or 2), selectable same-address collision
// policy, and a self-clearing init sequencer that zeroes every word after
// reset before ready_out rises.
// Optional feature: define FAKERAM_PARITY_EN to store one even-parity bit per
// word and report parity errors on reads (inj_par_err_in corrupts the stored
// parity of a write). Without it, parity_err_out is tied low.
module fakeram130_1r1w_init #(
    parameter int BITS        = 7,
    parameter int WORD_DEPTH  = 64,
    parameter int ADDR_WIDTH  = 6,
    parameter int RD_LATENCY  = 1,
    parameter int WRITE_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ready_out,
    input  logic                  rd_ce_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    output logic [BITS-1:0]       rd_out,
    output logic                  rd_valid_out,
    input  logic                  wr_ce_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [BITS-1:0]       wd_in,
    input  logic [BITS-1:0]       w_mask_in,
    input  logic                  inj_par_err_in,
    output logic                  parity_err_out
);

    typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  ready_q;

    logic [BITS-1:0]       mem_q [WORD_DEPTH];

    logic                  rd_in_range_s, wr_in_range_s;
    logic                  rd_fire_s, wr_fire_s, collide_s;
    logic [BITS-1:0]       merged_s;
    logic [BITS-1:0]       rd_data_s;
    logic                  rd_perr_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_waddr_s;
    logic [BITS-1:0]       mem_wdata_s;

    logic                  out_en_s;
    logic [BITS-1:0]       out_data_s;
    logic                  out_perr_s;

    logic [BITS-1:0]       rd_out_q;
    logic                  rd_valid_q;
    logic                  parity_err_q;

    // FSM state, init counter and ready flag; reset restarts the clear sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= (state_d == ST_READY);
        end
    end

    // Next state: sweep every word once in INIT, then stay in READY
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
                    state_d    = ST_READY;
                    init_cnt_d = '0;
                end else begin
                    state_d    = ST_INIT;
                    init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                state_d    = ST_READY;
                init_cnt_d = init_cnt_q;
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    assign rd_in_range_s = ({1'b0, rd_addr_in} < (ADDR_WIDTH + 1)'(WORD_DEPTH));
    assign wr_in_range_s = ({1'b0, wr_addr_in} < (ADDR_WIDTH + 1)'(WORD_DEPTH));
    assign rd_fire_s     = ready_q & rd_ce_in;
    assign wr_fire_s     = ready_q & wr_ce_in & wr_in_range_s;
    assign collide_s     = wr_fire_s & rd_ce_in & (rd_addr_in == wr_addr_in);
    assign merged_s      = (mem_q[wr_addr_in] & ~w_mask_in) | (wd_in & w_mask_in);

    // Array write port: zero fill during INIT, masked merge once ready
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_addr_in;
        mem_wdata_s = merged_s;
        if (state_q == ST_INIT) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = init_cnt_q;
            mem_wdata_s = '0;
        end else begin
            mem_we_s    = wr_fire_s;
            mem_waddr_s = wr_addr_in;
            mem_wdata_s = merged_s;
        end
    end

    // Data array; contents undefined until the init sweep completes
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Read word select: out-of-range reads return zero, collisions follow WRITE_FIRST
    always_comb begin
        rd_data_s = '0;
        if (!rd_in_range_s) begin
            rd_data_s = '0;
        end else if (collide_s && (WRITE_FIRST != 0)) begin
            rd_data_s = merged_s;
        end else begin
            rd_data_s = mem_q[rd_addr_in];
        end
    end

`ifdef FAKERAM_PARITY_EN
    logic            par_q [WORD_DEPTH];
    logic            mem_wpar_s;
    logic            wr_par_s;
    logic            rd_par_s;

    function automatic logic even_par(input logic [BITS-1:0] data);
        return ^data;
    endfunction

    assign wr_par_s = even_par(merged_s) ^ inj_par_err_in;

    // Parity bit for the word being written (INIT always stores correct parity of zero)
    always_comb begin
        mem_wpar_s = 1'b0;
        if (state_q == ST_INIT) begin
            mem_wpar_s = 1'b0;
        end else begin
            mem_wpar_s = wr_par_s;
        end
    end

    // Parity array, written alongside the data array
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            par_q[mem_waddr_s] <= mem_wpar_s;
        end
    end

    // Stored parity for the read word and the resulting error flag
    always_comb begin
        rd_par_s  = 1'b0;
        rd_perr_s = 1'b0;
        if (!rd_in_range_s) begin
            rd_par_s  = 1'b0;
            rd_perr_s = 1'b0;
        end else if (collide_s && (WRITE_FIRST != 0)) begin
            rd_par_s  = wr_par_s;
            rd_perr_s = even_par(rd_data_s) ^ rd_par_s;
        end else begin
            rd_par_s  = par_q[rd_addr_in];
            rd_perr_s = even_par(rd_data_s) ^ rd_par_s;
        end
    end
`else
    logic unused_inj_s;
    assign unused_inj_s = inj_par_err_in;
    assign rd_perr_s    = 1'b0;
`endif

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic            s1_valid_q;
            logic [BITS-1:0] s1_data_q;
            logic            s1_perr_q;

            // Extra pipeline stage; in-flight reads are dropped by reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                    s1_perr_q  <= 1'b0;
                end else begin
                    s1_valid_q <= rd_fire_s;
                    if (rd_fire_s) begin
                        s1_data_q <= rd_data_s;
                        s1_perr_q <= rd_perr_s;
                    end
                end
            end

            assign out_en_s   = s1_valid_q;
            assign out_data_s = s1_data_q;
            assign out_perr_s = s1_perr_q;
        end else begin : g_lat1
            assign out_en_s   = rd_fire_s;
            assign out_data_s = rd_data_s;
            assign out_perr_s = rd_perr_s;
        end
    endgenerate

    // Output stage: rd_out holds until the next completed read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_out_q     <= '0;
            rd_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rd_valid_q   <= out_en_s;
            parity_err_q <= out_en_s & out_perr_s;
            if (out_en_s) begin
                rd_out_q <= out_data_s;
            end
        end
    end

    assign ready_out      = ready_q;
    assign rd_out         = rd_out_q;
    assign rd_valid_out   = rd_valid_q;
    assign parity_err_out = parity_err_q;

endmodule

// File: tb/tb_fakeram130_1r1w_init.sv
// Directed bench for fakeram130_1r1w_init: four instances (default, 2-cycle
// latency, write-first, 40-word depth) share one stimulus stream.
module tb_fakeram130_1r1w_init;

    logic       clk;
    logic       rst_n;
    logic       rd_ce;
    logic [5:0] rd_addr;
    logic       wr_ce;
    logic [5:0] wr_addr;
    logic [6:0] wd;
    logic [6:0] w_mask;
    logic       inj;

    logic       rdy_a, vld_a, per_a;
    logic [6:0] out_a;
    logic       rdy_b, vld_b, per_b;
    logic [6:0] out_b;
    logic       rdy_c, vld_c, per_c;
    logic [6:0] out_c;
    logic       rdy_d, vld_d, per_d;
    logic [6:0] out_d;

    int checks;
    int errors;
    logic exp_perr;

    fakeram130_1r1w_init u_dut (
        .clk(clk), .rst_n(rst_n), .ready_out(rdy_a),
        .rd_ce_in(rd_ce), .rd_addr_in(rd_addr), .rd_out(out_a), .rd_valid_out(vld_a),
        .wr_ce_in(wr_ce), .wr_addr_in(wr_addr), .wd_in(wd), .w_mask_in(w_mask),
        .inj_par_err_in(inj), .parity_err_out(per_a)
    );

    fakeram130_1r1w_init #(.RD_LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .ready_out(rdy_b),
        .rd_ce_in(rd_ce), .rd_addr_in(rd_addr), .rd_out(out_b), .rd_valid_out(vld_b),
        .wr_ce_in(wr_ce), .wr_addr_in(wr_addr), .wd_in(wd), .w_mask_in(w_mask),
        .inj_par_err_in(inj), .parity_err_out(per_b)
    );

    fakeram130_1r1w_init #(.WRITE_FIRST(1)) u_wf (
        .clk(clk), .rst_n(rst_n), .ready_out(rdy_c),
        .rd_ce_in(rd_ce), .rd_addr_in(rd_addr), .rd_out(out_c), .rd_valid_out(vld_c),
        .wr_ce_in(wr_ce), .wr_addr_in(wr_addr), .wd_in(wd), .w_mask_in(w_mask),
        .inj_par_err_in(inj), .parity_err_out(per_c)
    );

    fakeram130_1r1w_init #(.WORD_DEPTH(40), .ADDR_WIDTH(6)) u_d40 (
        .clk(clk), .rst_n(rst_n), .ready_out(rdy_d),
        .rd_ce_in(rd_ce), .rd_addr_in(rd_addr), .rd_out(out_d), .rd_valid_out(vld_d),
        .wr_ce_in(wr_ce), .wr_addr_in(wr_addr), .wd_in(wd), .w_mask_in(w_mask),
        .inj_par_err_in(inj), .parity_err_out(per_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd_ce = 1'b0; rd_addr = 6'd0; wr_ce = 1'b0; wr_addr = 6'd0;
        wd = 7'h00; w_mask = 7'h00; inj = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rdy_a !== 1'b0)  begin errors++; $display("FAIL reset_ready: got %b expected 0", rdy_a); end
        checks++; if (vld_a !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b expected 0", vld_a); end
        checks++; if (out_a !== 7'h00) begin errors++; $display("FAIL reset_rd_out: got %h expected 00", out_a); end
        checks++; if (per_a !== 1'b0)  begin errors++; $display("FAIL reset_parity: got %b expected 0", per_a); end
        rst_n = 1'b1;
        for (int e = 1; e <= 64; e++) begin
            rd_ce   = (e == 10) ? 1'b1 : 1'b0;
            rd_addr = 6'd5;
            tick();
            checks++; if (rdy_a !== (e >= 64)) begin errors++; $display("FAIL init_ready edge %0d: got %b expected %b", e, rdy_a, (e >= 64)); end
            checks++; if (rdy_d !== (e >= 40)) begin errors++; $display("FAIL init_ready_d40 edge %0d: got %b expected %b", e, rdy_d, (e >= 40)); end
            checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL init_no_valid edge %0d: got %b expected 0", e, vld_a); end
            checks++; if (vld_b !== 1'b0) begin errors++; $display("FAIL init_no_valid_l2 edge %0d: got %b expected 0", e, vld_b); end
        end
        rd_ce = 1'b0;
    endtask

    task automatic test_init_clear();
        for (int a = 0; a < 64; a++) begin
            rd_ce = 1'b1; rd_addr = 6'(a);
            tick();
            checks++; if (vld_a !== 1'b1)  begin errors++; $display("FAIL clear_valid addr %0d: got %b expected 1", a, vld_a); end
            checks++; if (out_a !== 7'h00) begin errors++; $display("FAIL clear_data addr %0d: got %h expected 00", a, out_a); end
        end
        rd_ce = 1'b0;
        tick();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL clear_valid_drop: got %b expected 0", vld_a); end
    endtask

    task automatic test_write_mask();
        wr_ce = 1'b1; wr_addr = 6'd3; wd = 7'h7F; w_mask = 7'h7F;
        tick();
        wd = 7'h00; w_mask = 7'h0F;
        tick();
        wd = 7'h7F; w_mask = 7'h00;
        tick();
        wr_ce = 1'b0;
        rd_ce = 1'b1; rd_addr = 6'd3;
        tick();
        checks++; if (vld_a !== 1'b1)  begin errors++; $display("FAIL mask_valid: got %b expected 1", vld_a); end
        checks++; if (out_a !== 7'h70) begin errors++; $display("FAIL mask_data: got %h expected 70", out_a); end
        checks++; if (vld_b !== 1'b0)  begin errors++; $display("FAIL l2_not_yet: got %b expected 0", vld_b); end
        rd_addr = 6'd4;
        tick();
        checks++; if (out_a !== 7'h00) begin errors++; $display("FAIL mask_addr4: got %h expected 00", out_a); end
        checks++; if (vld_b !== 1'b1)  begin errors++; $display("FAIL l2_valid1: got %b expected 1", vld_b); end
        checks++; if (out_b !== 7'h70) begin errors++; $display("FAIL l2_data1: got %h expected 70", out_b); end
        rd_ce = 1'b0;
        tick();
        checks++; if (vld_a !== 1'b0)  begin errors++; $display("FAIL l1_idle: got %b expected 0", vld_a); end
        checks++; if (vld_b !== 1'b1)  begin errors++; $display("FAIL l2_valid2: got %b expected 1", vld_b); end
        checks++; if (out_b !== 7'h00) begin errors++; $display("FAIL l2_data2: got %h expected 00", out_b); end
        tick();
        checks++; if (vld_b !== 1'b0)  begin errors++; $display("FAIL l2_idle: got %b expected 0", vld_b); end
    endtask

    task automatic test_collision();
        wr_ce = 1'b1; wr_addr = 6'd9; wd = 7'h11; w_mask = 7'h7F;
        tick();
        wd = 7'h22; rd_ce = 1'b1; rd_addr = 6'd9;
        tick();
        checks++; if (out_a !== 7'h11) begin errors++; $display("FAIL coll_read_first: got %h expected 11", out_a); end
        checks++; if (vld_a !== 1'b1)  begin errors++; $display("FAIL coll_valid: got %b expected 1", vld_a); end
        checks++; if (out_c !== 7'h22) begin errors++; $display("FAIL coll_write_first: got %h expected 22", out_c); end
        wr_ce = 1'b0;
        tick();
        checks++; if (out_a !== 7'h22) begin errors++; $display("FAIL coll_after_rf: got %h expected 22", out_a); end
        checks++; if (out_c !== 7'h22) begin errors++; $display("FAIL coll_after_wf: got %h expected 22", out_c); end
        rd_ce = 1'b0;
        tick();
        checks++; if (vld_a !== 1'b0)  begin errors++; $display("FAIL hold_valid: got %b expected 0", vld_a); end
        checks++; if (out_a !== 7'h22) begin errors++; $display("FAIL hold_data: got %h expected 22", out_a); end
    endtask

    task automatic test_out_of_range();
        wr_ce = 1'b1; wr_addr = 6'd45; wd = 7'h55; w_mask = 7'h7F;
        tick();
        wr_ce = 1'b0;
        rd_ce = 1'b1; rd_addr = 6'd45;
        tick();
        checks++; if (vld_d !== 1'b1)  begin errors++; $display("FAIL oor_valid: got %b expected 1", vld_d); end
        checks++; if (out_d !== 7'h00) begin errors++; $display("FAIL oor_data: got %h expected 00", out_d); end
        checks++; if (per_d !== 1'b0)  begin errors++; $display("FAIL oor_parity: got %b expected 0", per_d); end
        checks++; if (out_a !== 7'h55) begin errors++; $display("FAIL inrange_45: got %h expected 55", out_a); end
        rd_addr = 6'd5;
        tick();
        checks++; if (out_d !== 7'h00) begin errors++; $display("FAIL oor_alias5: got %h expected 00", out_d); end
        rd_ce = 1'b0;
    endtask

    task automatic test_parity();
`ifdef FAKERAM_PARITY_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        wr_ce = 1'b1; wr_addr = 6'd7; wd = 7'h03; w_mask = 7'h7F; inj = 1'b1;
        tick();
        wr_ce = 1'b0; inj = 1'b0;
        rd_ce = 1'b1; rd_addr = 6'd7;
        tick();
        checks++; if (vld_a !== 1'b1)   begin errors++; $display("FAIL par_valid: got %b expected 1", vld_a); end
        checks++; if (out_a !== 7'h03)  begin errors++; $display("FAIL par_data: got %h expected 03", out_a); end
        checks++; if (per_a !== exp_perr) begin errors++; $display("FAIL par_injected: got %b expected %b", per_a, exp_perr); end
        rd_ce = 1'b0;
        tick();
        checks++; if (per_a !== 1'b0)   begin errors++; $display("FAIL par_idle: got %b expected 0", per_a); end
        wr_ce = 1'b1;
        tick();
        wr_ce = 1'b0;
        rd_ce = 1'b1;
        tick();
        checks++; if (per_a !== 1'b0)   begin errors++; $display("FAIL par_clean: got %b expected 0", per_a); end
        checks++; if (out_a !== 7'h03)  begin errors++; $display("FAIL par_clean_data: got %h expected 03", out_a); end
        rd_ce = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        rd_ce = 1'b1; rd_addr = 6'd1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (vld_d !== 1'b0)  begin errors++; $display("FAIL rst_valid_d40: got %b expected 0", vld_d); end
        checks++; if (rdy_d !== 1'b0)  begin errors++; $display("FAIL rst_ready_d40: got %b expected 0", rdy_d); end
        checks++; if (out_a !== 7'h00) begin errors++; $display("FAIL rst_rd_out: got %h expected 00", out_a); end
        @(posedge clk);
        #1;
        checks++; if (vld_b !== 1'b0)  begin errors++; $display("FAIL rst_inflight_l2: got %b expected 0", vld_b); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            checks++; if (rdy_d !== (e >= 40)) begin errors++; $display("FAIL reinit_ready edge %0d: got %b expected %b", e, rdy_d, (e >= 40)); end
            checks++; if (vld_d !== 1'b0) begin errors++; $display("FAIL reinit_valid edge %0d: got %b expected 0", e, vld_d); end
        end
        rd_ce = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_init_clear();
        test_write_mask();
        test_collision();
        test_out_of_range();
        test_parity();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
